// File: rtl/bridge_router.sv
// bridge_router: decodes one upstream bridge request stream onto NUM_LEAVES
// address windows, forwards registered strobes/address/data to the selected
// leaf and returns leaf read data through a latency-matched pipeline.

// Per-leaf window compare and optional rebase. Window bounds come in as ports
// so that a zero base does not collapse into a constant compare.
module bridge_router_leaf #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [ADDR_WIDTH-1:0] from_addr,
   input  logic [ADDR_WIDTH-1:0] to_addr,
   input  logic                  rebase,
   output logic                  hit,
   output logic [ADDR_WIDTH-1:0] leaf_addr
);

   // inclusive unsigned window; from > to can never satisfy both terms
   always_comb begin
      hit       = (addr >= from_addr) && (addr <= to_addr);
      leaf_addr = rebase ? (addr - from_addr) : addr;
   end

endmodule

module bridge_router #(
   parameter int                              NUM_LEAVES      = 6,
   parameter int                              ADDR_WIDTH      = 32,
   parameter int                              DATA_WIDTH      = 32,
   parameter logic [NUM_LEAVES*ADDR_WIDTH-1:0] FROM_ADDRS      = '0,
   parameter logic [NUM_LEAVES*ADDR_WIDTH-1:0] TO_ADDRS        = '0,
   parameter logic [NUM_LEAVES-1:0]           REBASE          = '0,
   parameter int                              ENDIAN_LITTLE   = 1,
   parameter int                              LEAF_RD_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0]           DEFAULT_RD_DATA = {DATA_WIDTH{1'b1}}
) (
   input  logic                             clk_74a,
   input  logic                             reset_n,
   input  logic [ADDR_WIDTH-1:0]            up_addr,
   input  logic                             up_wr,
   input  logic [DATA_WIDTH-1:0]            up_wr_data,
   input  logic                             up_rd,
   output logic [DATA_WIDTH-1:0]            up_rd_data,
   output logic                             up_rd_valid,
   output logic [ADDR_WIDTH-1:0]            leaf_addr,
   output logic [DATA_WIDTH-1:0]            leaf_wr_data,
   output logic [NUM_LEAVES-1:0]            leaf_wr,
   output logic [NUM_LEAVES-1:0]            leaf_rd,
   input  logic [NUM_LEAVES*DATA_WIDTH-1:0] leaf_rd_data,
   output logic [15:0]                      unmapped_count,
   output logic                             protocol_err
);

   localparam int LAT   = LEAF_RD_LATENCY;
   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

   // byte k <-> byte NB-1-k; used on both the write and read paths
   function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < NB; k++) r[k*8 +: 8] = d[(NB-1-k)*8 +: 8];
      return r;
   endfunction

   logic [NUM_LEAVES-1:0]                 hit;
   logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] leaf_addr_v;
   logic [NUM_LEAVES-1:0][DATA_WIDTH-1:0] leaf_data_v;
   logic [NUM_LEAVES-1:0]                 sel_onehot;
   logic [IDX_W-1:0]                      sel_idx;
   logic                                  any_hit;
   logic [ADDR_WIDTH-1:0]                 sel_addr;
   logic [DATA_WIDTH-1:0]                 wr_data_adj;
   logic                                  rd_go;
   logic                                  acc_go;

   // read pipeline: stage k is valid during T+1+k
   logic [LAT:0]                          vld_pipe;
   logic [LAT:0]                          hit_pipe;
   logic [LAT:0][IDX_W-1:0]               idx_pipe;
   logic [DATA_WIDTH-1:0]                 rd_pick;

   assign leaf_data_v = leaf_rd_data;

   genvar gi;
   for (gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf
      bridge_router_leaf #(.ADDR_WIDTH(ADDR_WIDTH)) u_leaf (
         .addr      (up_addr),
         .from_addr (FROM_ADDRS[gi*ADDR_WIDTH +: ADDR_WIDTH]),
         .to_addr   (TO_ADDRS[gi*ADDR_WIDTH +: ADDR_WIDTH]),
         .rebase    (REBASE[gi]),
         .hit       (hit[gi]),
         .leaf_addr (leaf_addr_v[gi])
      );
   end

   // lowest-index hit wins when windows overlap; a write masks a same-cycle read
   always_comb begin
      sel_onehot = '0;
      sel_idx    = '0;
      for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            sel_idx       = IDX_W'(i);
         end
      end
      any_hit     = |hit;
      sel_addr    = leaf_addr_v[sel_idx];
      wr_data_adj = (ENDIAN_LITTLE != 0) ? up_wr_data : byte_swap(up_wr_data);
      rd_go       = up_rd && !up_wr;
      acc_go      = up_rd || up_wr;
   end

   // stage 0->1: one-cycle strobes; address and data hold between mapped requests
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         leaf_addr    <= '0;
         leaf_wr_data <= '0;
         leaf_wr      <= '0;
         leaf_rd      <= '0;
      end else begin
         leaf_wr <= (up_wr && any_hit) ? sel_onehot : '0;
         leaf_rd <= (rd_go && any_hit) ? sel_onehot : '0;
         if (acc_go && any_hit) leaf_addr <= sel_addr;
         if (up_wr && any_hit) leaf_wr_data <= wr_data_adj;
      end
   end

   // saturating unmapped counter and sticky wr+rd collision flag
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         unmapped_count <= '0;
         protocol_err   <= 1'b0;
      end else begin
         if (acc_go && !any_hit && unmapped_count != 16'hFFFF)
            unmapped_count <= unmapped_count + 16'd1;
         if (up_wr && up_rd) protocol_err <= 1'b1;
      end
   end

   // shift the selected leaf and hit flag alongside the read valid bit
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         hit_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_go;
         hit_pipe[0] <= any_hit;
         idx_pipe[0] <= sel_idx;
         for (int k = 1; k <= LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            hit_pipe[k] <= hit_pipe[k-1];
            idx_pipe[k] <= idx_pipe[k-1];
         end
      end
   end

   // pick leaf data at T+1+LAT; the unmapped default bypasses the swap
   always_comb begin
      rd_pick = DEFAULT_RD_DATA;
      if (hit_pipe[LAT])
         rd_pick = (ENDIAN_LITTLE != 0) ? leaf_data_v[idx_pipe[LAT]]
                                        : byte_swap(leaf_data_v[idx_pipe[LAT]]);
   end

   // register the return; data holds until the next read completes
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         up_rd_data  <= DEFAULT_RD_DATA;
         up_rd_valid <= 1'b0;
      end else begin
         up_rd_valid <= vld_pipe[LAT];
         if (vld_pipe[LAT]) up_rd_data <= rd_pick;
      end
   end

endmodule
